// File: rtl/weight_row_buffer_if.sv
// weight_row_buffer_if: row stream from the weight row buffer to the array weight loader
interface weight_row_buffer_if #(
   parameter int DATA_WIDTH = 256
);
   logic [DATA_WIDTH-1:0] row_data;
   logic                  row_last;
   logic                  row_valid;
   logic                  row_ready;
   modport master (output row_data, row_last, row_valid, input row_ready);
   modport slave (input row_data, row_last, row_valid, output row_ready);
endinterface

// File: rtl/weight_row_buffer.sv
// weight_row_buffer: captures BRAM read words after the read latency, queues them and streams tagged rows
module weight_row_buffer #(
   parameter int DATA_WIDTH    = 256,
   parameter int READ_LATENCY  = 1,
   parameter int FIFO_DEPTH    = 8,
   parameter int ROWS_PER_TILE = 32,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          bram_en_in,
   input  logic [DATA_WIDTH-1:0]         bram_dout,
   input  logic                          row_cnt_clr,
   output logic                          fetch_hold,
   weight_row_buffer_if.master           row,
   output logic [$clog2(FIFO_DEPTH):0]   occupancy,
   output logic [CNT_WIDTH-1:0]          tiles_done,
   output logic                          overflow_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = ROWS_PER_TILE > 1 ? $clog2(ROWS_PER_TILE) : 1;
   logic [READ_LATENCY-1:0] dly, dly_next;
   logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [RW-1:0]           row_cnt;
   logic [AW:0]             occ_next;
   logic                    cap, pop, full, push, drop, tag;
   always_comb begin
      dly_next = READ_LATENCY'({dly, bram_en_in});
      cap      = dly[READ_LATENCY-1];
      pop      = row.row_valid & row.row_ready;
      full     = occupancy == (AW+1)'(FIFO_DEPTH);
      // a pop in the same cycle frees the slot, so a full buffer still accepts the capture
      push     = cap & (~full | pop);
      drop     = cap & full & ~pop;
      occ_next = occupancy + (AW+1)'(push) - (AW+1)'(pop);
      tag      = row_cnt == RW'(ROWS_PER_TILE-1);
   end
   assign row.row_data  = mem[rd_ptr][DATA_WIDTH-1:0];
   assign row.row_last  = mem[rd_ptr][DATA_WIDTH];
   assign row.row_valid = occupancy != '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         dly          <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         occupancy    <= '0;
         row_cnt      <= '0;
         tiles_done   <= '0;
         fetch_hold   <= 1'b0;
         overflow_err <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         dly        <= dly_next;
         occupancy  <= occ_next;
         // reads already issued must still find room, so count them against the free space
         fetch_hold <= int'(occ_next) + $countones(dly_next) >= FIFO_DEPTH - 1;
         if (push) begin
            mem[wr_ptr] <= {tag, bram_dout};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (row.row_last) tiles_done <= tiles_done + 1'b1;
         end
         if (row_cnt_clr) row_cnt <= '0;
         else if (push) row_cnt <= tag ? '0 : row_cnt + 1'b1;
         if (drop) overflow_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_weight_row_buffer.sv
// tb_weight_row_buffer: directed checks of capture timing, backpressure, full/overflow, tile tagging and reset
module tb_weight_row_buffer;
   logic         clk, rst, bram_en_in, row_cnt_clr, fetch_hold, overflow_err;
   logic [255:0] bram_dout;
   logic [3:0]   occupancy;
   logic [15:0]  tiles_done;
   int           rd_addr, n_checks, n_fail;
   int           first, k, lasts, last_at, hold_seen, issued, rise;

   weight_row_buffer_if #(.DATA_WIDTH(256)) rif ();

   weight_row_buffer dut (
      .clk(clk), .rst(rst), .bram_en_in(bram_en_in), .bram_dout(bram_dout),
      .row_cnt_clr(row_cnt_clr), .fetch_hold(fetch_hold), .row(rif),
      .occupancy(occupancy), .tiles_done(tiles_done), .overflow_err(overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] word(input int i);
      return {8{i}};
   endfunction

   // one-cycle read latency BRAM model
   always_ff @(posedge clk) if (bram_en_in) bram_dout <= word(rd_addr);

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      bram_en_in = 1'b0;
      row_cnt_clr = 1'b0;
      rif.row_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_valid"}, rif.row_valid, 0);
      check({tag, "_last"}, rif.row_last, 0);
      check({tag, "_data"}, rif.row_data, 0);
      check({tag, "_occ"}, occupancy, 0);
      check({tag, "_tiles"}, tiles_done, 0);
      check({tag, "_hold"}, fetch_hold, 0);
      check({tag, "_ovf"}, overflow_err, 0);
   endtask

   task automatic drain(input string tag, input int base, input int n);
      int got = 0;
      rif.row_ready = 1'b1;
      for (int c = 0; c < n + 4; c++) begin
         if (rif.row_valid) begin
            check({tag, "_data"}, rif.row_data, word(base + got));
            got++;
         end
         step();
      end
      rif.row_ready = 1'b0;
      check({tag, "_count"}, got, n);
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rd_addr = 0;
      bram_dout = '0;
      reset_dut();
      check_reset("reset");

      // basic stream of one full tile
      first = -1; k = 0; lasts = 0; last_at = -1; hold_seen = 0;
      rif.row_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         bram_en_in = c < 32;
         rd_addr = c;
         if (fetch_hold) hold_seen = 1;
         if (rif.row_valid) begin
            if (first < 0) first = c;
            check("stream_data", rif.row_data, word(k));
            if (rif.row_last) begin lasts++; last_at = k; end
            k++;
         end
         step();
      end
      bram_en_in = 1'b0;
      rif.row_ready = 1'b0;
      check("stream_first_valid", first, 2);
      check("stream_rows", k, 32);
      check("stream_last_count", lasts, 1);
      check("stream_last_pos", last_at, 31);
      check("stream_tiles", tiles_done, 1);
      check("stream_hold_seen", hold_seen, 0);

      // backpressure with a hold-obeying fetcher
      reset_dut();
      issued = 0; rise = -1;
      for (int c = 0; c < 14; c++) begin
         if (fetch_hold && rise < 0) rise = c;
         bram_en_in = (c < 12) && !fetch_hold;
         rd_addr = 100 + issued;
         if (bram_en_in) issued++;
         step();
      end
      bram_en_in = 1'b0;
      check("bp_hold_rise", rise, 7);
      check("bp_issued", issued, 7);
      check("bp_occ", occupancy, 7);
      check("bp_hold_high", fetch_hold, 1);
      check("bp_ovf", overflow_err, 0);
      drain("bp_drain", 100, 7);
      check("bp_hold_drop", fetch_hold, 0);
      check("bp_occ_empty", occupancy, 0);

      // full buffer with capture and pop in the same cycle
      reset_dut();
      for (int c = 0; c < 10; c++) begin
         bram_en_in = c < 9;
         rd_addr = 200 + c;
         rif.row_ready = c == 9;
         if (c == 9) check("fullpp_occ_before", occupancy, 8);
         step();
      end
      bram_en_in = 1'b0;
      rif.row_ready = 1'b0;
      check("fullpp_occ_after", occupancy, 8);
      check("fullpp_ovf", overflow_err, 0);
      drain("fullpp_drain", 201, 8);

      // overflow: extra capture into a full buffer is dropped
      reset_dut();
      for (int c = 0; c < 10; c++) begin
         bram_en_in = c < 9;
         rd_addr = 300 + c;
         if (c == 9) check("ovf_before", overflow_err, 0);
         step();
      end
      bram_en_in = 1'b0;
      check("ovf_set", overflow_err, 1);
      check("ovf_occ", occupancy, 8);
      step(); step(); step();
      check("ovf_sticky", overflow_err, 1);
      drain("ovf_drain", 300, 8);
      check("ovf_sticky_drained", overflow_err, 1);

      // tile realignment coinciding with the 10th push
      reset_dut();
      k = 0; lasts = 0; last_at = -1;
      rif.row_ready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         bram_en_in = c < 42;
         rd_addr = c;
         row_cnt_clr = c == 10;
         if (rif.row_valid) begin
            if (rif.row_last) begin lasts++; last_at = k; end
            k++;
         end
         step();
      end
      bram_en_in = 1'b0;
      row_cnt_clr = 1'b0;
      rif.row_ready = 1'b0;
      check("tile_rows", k, 42);
      check("tile_last_count", lasts, 1);
      check("tile_last_pos", last_at, 41);
      check("tile_tiles", tiles_done, 1);

      // reset with three rows stored and one read in flight
      reset_dut();
      for (int c = 0; c < 4; c++) begin
         bram_en_in = 1'b1;
         rd_addr = 400 + c;
         step();
      end
      bram_en_in = 1'b0;
      check("midrst_occ_before", occupancy, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset("midrst");
      step(); step();
      check("midrst_no_capture", occupancy, 0);
      check("midrst_no_valid", rif.row_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
